// File: rtl/seg7_pkg.sv
// Shared types and segment tables for the 7-segment frame loader.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    SHIFT
  } state_t;

  // Active-high {g,f,e,d,c,b,a}, entry 0 at the LSBs
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic logic [7:0] seg_pol(
    input logic [7:0] raw,
    input bit         act_low
  );
    return act_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/seg7_frame_loader_if.sv
// Start/EN/PData handshake between the frame loader and the serial shifter.
interface seg7_frame_loader_if #(
  parameter int DIGITS = 8
);

  logic                  p2s_start;
  logic [8*DIGITS-1:0]   p2s_pdata;
  logic                  p2s_en;

  modport master (
    output p2s_start,
    output p2s_pdata,
    input  p2s_en
  );

  modport slave (
    input  p2s_start,
    input  p2s_pdata,
    output p2s_en
  );

endinterface

// File: rtl/seg7_hex_enc.sv
// One digit: hex nibble plus enable and decimal point to a segment byte.
module seg7_hex_enc
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] raw;

  always_comb begin
    raw = SEG_OFF;
    if (en) begin
      raw = {dp, SEG_TABLE[nib]};
    end
    seg = seg_pol(raw, SEG_ACTIVE_LOW);
  end

endmodule

// File: rtl/seg7_frame_loader.sv
// Builds a segment frame and hands it to the serial shifter on request
// or periodic refresh, coalescing requests seen during a transfer.
module seg7_frame_loader
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int REFRESH_DIV    = 50_000_000,
  parameter int TIMEOUT        = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   hex_data,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  update,
  seg7_frame_loader_if.master   p2s,
  output logic                  busy,
  output logic                  err
);

  localparam int         FW       = 8 * DIGITS;
  localparam logic [7:0] OFF_B    = seg_pol(SEG_OFF, SEG_ACTIVE_LOW);
  localparam bit         REF_ON   = (REFRESH_DIV != 0);
  localparam logic [31:0] REF_LAST =
    REF_ON ? 32'(REFRESH_DIV - 1) : 32'd0;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t          state;
  logic [FW-1:0]   frame;
  logic [FW-1:0]   pdata_q;
  logic            start_q;
  logic            pend;
  logic [31:0]     ref_cnt;
  logic [31:0]     to_cnt;
  logic            tick;
  logic            trig;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg7_hex_enc #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_enc (
      .nib (hex_data[4*i +: 4]),
      .en  (dig_en[i]),
      .dp  (dp[i]),
      .seg (frame[8*i +: 8])
    );
  end

  assign tick = REF_ON && (ref_cnt == REF_LAST);
  assign trig = update | tick;

  assign p2s.p2s_start = start_q;
  assign p2s.p2s_pdata = pdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_cnt <= '0;
    end else if (!REF_ON || tick) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      start_q <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      pend    <= 1'b0;
      to_cnt  <= '0;
      pdata_q <= {DIGITS{OFF_B}};
    end else begin
      if (trig && state != IDLE) begin
        pend <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (trig || pend) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          // a trigger landing in LOAD itself still earns a follow-up
          pdata_q <= frame;
          pend    <= trig;
          to_cnt  <= '0;
          start_q <= 1'b1;
          state   <= START;
        end
        START: begin
          if (!p2s.p2s_en) begin
            start_q <= 1'b0;
            state   <= SHIFT;
          end else if (to_cnt == TO_LAST) begin
            start_q <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        SHIFT: begin
          if (p2s.p2s_en) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
